// File: rtl/mirfak_issue_ctrl.sv
// Mirfak decode-stage issue controller: IF/ID register, 32-entry RAW/WAW scoreboard,
// bounded in-flight counter and a fence drain FSM deciding when ID may issue to EX.
module mirfak_issue_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             if_valid_i,
    input  logic [31:0]      if_instr_i,
    output logic             if_ready_o,
    output logic [31:0]      id_instr_o,
    input  logic             id_rs1_use_i,
    input  logic             id_rs2_use_i,
    input  logic             id_rd_we_i,
    input  logic             id_fence_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [31:0]      ex_instr_o,
    input  logic             cmp_valid_i,
    input  logic             cmp_we_i,
    input  logic [4:0]       cmp_rd_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             idValid_q, idValid_d;
    logic [31:0]      idInstr_q, idInstr_d;
    logic [31:0]      sb_q, sb_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [4:0]  rs1, rs2, rd;
    logic        hazard, full, countZero, fenceBlock;
    logic        exValid, issue, ifReady, load;
    logic [31:0] setMask, clrMask;

    assign rs1 = idInstr_q[19:15];
    assign rs2 = idInstr_q[24:20];
    assign rd  = idInstr_q[11:7];

    // Hazard looks only at the registered scoreboard, so a completion frees its
    // register one cycle later; sb[0] is held at zero which keeps x0 hazard-free.
    assign hazard = (id_rs1_use_i & sb_q[rs1])
                  | (id_rs2_use_i & sb_q[rs2])
                  | (id_rd_we_i   & sb_q[rd]);

    assign countZero  = (count_q == '0);
    assign full       = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fenceBlock = id_fence_i & ~countZero;

    assign exValid = idValid_q & ~hazard & ~full & ~fenceBlock & ~flush_i;
    assign issue   = exValid & ex_ready_i;
    assign ifReady = ~flush_i & (~idValid_q | issue) & (state_q != DRAIN);
    assign load    = if_valid_i & ifReady;

    assign if_ready_o = ifReady;
    assign ex_valid_o = exValid;
    assign id_instr_o = idInstr_q;
    assign ex_instr_o = idInstr_q;
    assign busy_o     = idValid_q | ~countZero;
    assign err_o      = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (idValid_q && id_fence_i && !countZero) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (countZero) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (flush_i) begin
            state_d = RUN;
        end
    end

    // ID register: flush beats a new load, which beats the issue-clear.
    always_comb begin
        idValid_d = idValid_q;
        idInstr_d = idInstr_q;
        if (flush_i) begin
            idValid_d = 1'b0;
        end else if (load) begin
            idValid_d = 1'b1;
            idInstr_d = if_instr_i;
        end else if (issue) begin
            idValid_d = 1'b0;
        end
    end

    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (issue && id_rd_we_i) begin
            setMask = 32'd1 << rd;
        end
        if (cmp_valid_i && cmp_we_i) begin
            clrMask = 32'd1 << cmp_rd_i;
        end
        sb_d    = (sb_q & ~clrMask) | setMask;
        sb_d[0] = 1'b0;
    end

    // A completion with nothing outstanding is a protocol error; the counter saturates at zero.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        case ({issue, cmp_valid_i})
            2'b10: count_d = count_q + CNT_W'(1);
            2'b01: begin
                if (countZero) begin
                    err_d = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idValid_q <= 1'b0;
            idInstr_q <= '0;
            sb_q      <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            idValid_q <= idValid_d;
            idInstr_q <= idInstr_d;
            sb_q      <= sb_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mirfak_issue_ctrl.sv
// Randomized scoreboard bench for mirfak_issue_ctrl against an in-flight-list reference model.
module tb_mirfak_issue_ctrl;

    localparam int MAX = 4;

    typedef struct {
        logic [4:0] rd;
        logic       we;
    } flight_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        if_valid_i;
    logic [31:0] if_instr_i;
    logic        if_ready_o;
    logic [31:0] id_instr_o;
    logic        id_rs1_use_i, id_rs2_use_i, id_rd_we_i, id_fence_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] ex_instr_o;
    logic        cmp_valid_i, cmp_we_i;
    logic [4:0]  cmp_rd_i;
    logic        flush_i;
    logic        busy_o, err_o;

    int assertCount = 0;
    int failCount   = 0;

    flight_t     inflight[$];
    logic [31:0] expQ[$];
    logic        mIdValid;
    logic [31:0] mIdInstr;
    logic        mDrain;
    logic        mErr;
    int          cmpIdx;
    logic [3:0]  dutDec;

    always #5 clk = ~clk;

    mirfak_issue_ctrl #(.MAX_OUTSTANDING(MAX), .CNT_W(3)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_ready_o(if_ready_o),
        .id_instr_o(id_instr_o),
        .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
        .id_rd_we_i(id_rd_we_i), .id_fence_i(id_fence_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_instr_o(ex_instr_o),
        .cmp_valid_i(cmp_valid_i), .cmp_we_i(cmp_we_i), .cmp_rd_i(cmp_rd_i),
        .flush_i(flush_i), .busy_o(busy_o), .err_o(err_o)
    );

    // {rs1 use, rs2 use, rd write, fence} for the handful of opcodes the bench generates
    function automatic logic [3:0] decode(input logic [31:0] instr);
        case (instr[6:0])
            7'b0010011: return 4'b1010;
            7'b0110011: return 4'b1110;
            7'b0000011: return 4'b1010;
            7'b0100011: return 4'b1100;
            7'b0001111: return 4'b0001;
            default:    return 4'b0000;
        endcase
    endfunction

    always_comb dutDec = decode(id_instr_o);
    assign id_rs1_use_i = dutDec[3];
    assign id_rs2_use_i = dutDec[2];
    assign id_rd_we_i   = dutDec[1];
    assign id_fence_i   = dutDec[0];

    function automatic logic [31:0] genInstr();
        logic [6:0] opc;
        int kind;
        kind = $urandom_range(0, 11);
        if (kind < 3)       opc = 7'b0010011;
        else if (kind < 7)  opc = 7'b0110011;
        else if (kind < 9)  opc = 7'b0000011;
        else if (kind < 11) opc = 7'b0100011;
        else                opc = 7'b0001111;
        return {7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'd0,
                5'($urandom_range(0, 7)), opc};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        mIdValid = 1'b0;
        mIdInstr = '0;
        mDrain   = 1'b0;
        mErr     = 1'b0;
        inflight.delete();
        expQ.delete();
    endtask

    task automatic applyStimulus(input int ifPct, input int cmpPct, input int flushPct, input int readyPct);
        if_valid_i = ($urandom_range(0, 99) < ifPct);
        if_instr_i = genInstr();
        ex_ready_i = ($urandom_range(0, 99) < readyPct);
        flush_i    = ($urandom_range(0, 99) < flushPct);
        if (inflight.size() > 0 && $urandom_range(0, 99) < cmpPct) begin
            cmpIdx      = $urandom_range(0, inflight.size() - 1);
            cmp_valid_i = 1'b1;
            cmp_we_i    = inflight[cmpIdx].we;
            cmp_rd_i    = inflight[cmpIdx].rd;
        end else begin
            cmpIdx      = -1;
            cmp_valid_i = 1'b0;
            cmp_we_i    = 1'($urandom_range(0, 1));
            cmp_rd_i    = 5'($urandom_range(0, 31));
        end
    endtask

    // One cycle of the reference model: compare visible outputs, then advance model state.
    task automatic modelStep();
        logic [3:0] dec;
        logic [4:0] rs1, rs2, rd;
        logic       hazard, expValid, issue, expIfReady;
        int         n;
        dec = decode(mIdInstr);
        rs1 = mIdInstr[19:15];
        rs2 = mIdInstr[24:20];
        rd  = mIdInstr[11:7];
        n   = inflight.size();
        hazard = 1'b0;
        foreach (inflight[i]) begin
            if (inflight[i].we &&
                ((dec[3] && inflight[i].rd == rs1) ||
                 (dec[2] && inflight[i].rd == rs2) ||
                 (dec[1] && inflight[i].rd == rd)))
                hazard = 1'b1;
        end
        expValid   = mIdValid && !hazard && (n < MAX) && !(dec[0] && n != 0) && !flush_i;
        issue      = expValid && ex_ready_i;
        expIfReady = !flush_i && (!mIdValid || issue) && !mDrain;

        checkOutput("ex_valid", ex_valid_o, expValid);
        checkOutput("if_ready", if_ready_o, expIfReady);
        checkOutput("busy", busy_o, mIdValid || n != 0);
        checkOutput("err", err_o, mErr);
        if (mIdValid) checkOutput("id_instr", id_instr_o, mIdInstr);

        if (cmp_valid_i) begin
            if (cmpIdx >= 0) inflight.delete(cmpIdx);
            else if (n == 0 && !issue) mErr = 1'b1;
        end
        if (issue) inflight.push_back('{rd: rd, we: dec[1] && rd != 0});

        if (flush_i) mDrain = 1'b0;
        else if (!mDrain && mIdValid && dec[0] && n != 0) mDrain = 1'b1;
        else if (mDrain && n == 0) mDrain = 1'b0;

        if (flush_i) begin
            if (mIdValid && expQ.size() > 0) void'(expQ.pop_back());
            mIdValid = 1'b0;
        end else if (if_valid_i && expIfReady) begin
            mIdValid = 1'b1;
            mIdInstr = if_instr_i;
            expQ.push_back(if_instr_i);
        end else if (issue) begin
            mIdValid = 1'b0;
        end
    endtask

    // Issue monitor: every EX handshake must hand over the oldest captured, unsquashed instruction.
    always @(negedge clk) begin
        #1;
        if (rst_ni && ex_valid_o && ex_ready_i) begin
            if (expQ.size() == 0) begin
                checkOutput("issue_unexpected", ex_instr_o, 32'hxxxx_xxxx);
            end else begin
                checkOutput("ex_instr", ex_instr_o, expQ.pop_front());
            end
        end
    end

    task automatic runCycles(input int cycles, input int ifPct, input int cmpPct,
                             input int flushPct, input int readyPct);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(ifPct, cmpPct, flushPct, readyPct);
            @(negedge clk);
            modelStep();
        end
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_ex_valid", ex_valid_o, 1'b0);
        checkOutput("rst_if_ready", if_ready_o, 1'b1);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_err", err_o, 1'b0);
    endtask

    initial begin
        int guard;
        rst_ni      = 1'b0;
        if_valid_i  = 1'b0;
        if_instr_i  = '0;
        ex_ready_i  = 1'b0;
        cmp_valid_i = 1'b0;
        cmp_we_i    = 1'b0;
        cmp_rd_i    = '0;
        flush_i     = 1'b0;
        cmpIdx      = -1;
        resetModel();
        repeat (2) @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1 rst_ni = 1'b1;

        runCycles(3000, 70, 35, 4, 75);

        // Squash ID, then retire everything still in flight.
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 100, 0);
        @(negedge clk);
        modelStep();
        guard = 0;
        while (inflight.size() > 0 && guard < 200) begin
            runCycles(1, 0, 100, 0, 0);
            guard++;
        end
        checkOutput("drain_done", inflight.size(), 0);
        checkOutput("expq_empty", expQ.size(), 0);

        // Completion with nothing outstanding must raise the sticky error.
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 0);
        cmp_valid_i = 1'b1;
        cmp_we_i    = 1'b1;
        cmp_rd_i    = 5'd3;
        @(negedge clk);
        modelStep();
        runCycles(3, 0, 0, 0, 0);
        checkOutput("err_sticky", err_o, 1'b1);

        // Asynchronous reset in the middle of traffic.
        runCycles(40, 80, 30, 0, 80);
        @(posedge clk);
        #3 rst_ni = 1'b0;
        #1;
        checkResetOutputs();
        if_valid_i  = 1'b0;
        cmp_valid_i = 1'b0;
        flush_i     = 1'b0;
        resetModel();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        runCycles(400, 70, 35, 4, 75);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
